// File: rtl/clint_pkg.sv
// clint_pkg: address map, FSM states and byte-merge helper shared by the clint_timer files
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
    localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    function automatic logic [63:0] merge_bytes(
        input logic [63:0] old_val,
        input logic [63:0] new_val,
        input logic [7:0]  mask
    );
        logic [63:0] res;
        for (int i = 0; i < 8; i++)
            res[i*8 +: 8] = mask[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// clint_timer_if: LSU request/response channel into the CLINT
//   master (LSU): req_valid, req_wen, req_addr[15:0], req_wdata[63:0], req_wmask[7:0], resp_ready
//   slave (CLINT): req_ready, resp_valid, resp_rdata[63:0], resp_err
interface clint_timer_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/clint_prescaler.sv
// clint_prescaler: divides clk by TICK_DIV, pulsing tick once per period
//   clk, rst (async, active-high) in; tick out (high when count == TICK_DIV-1)
module clint_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;

endmodule

// File: rtl/clint_timer.sv
// clint_timer: memory-mapped mtime/mtimecmp/msip block driving mtip/msip to the CSR unit
//   clk, rst (async, active-high)
//   bus   : clint_timer_if.slave request/response channel from the LSU
//   mtip  : out, mtime >= mtimecmp (unsigned)
//   msip  : out, software interrupt bit
//   Build option CLINT_WMASK_EN: honour req_wmask per byte on writes.
module clint_timer
    import clint_pkg::*;
#(
    parameter int          TICK_DIV  = 1,
    parameter logic [63:0] MTIME_RST = 64'd0
) (
    input  logic         clk,
    input  logic         rst,
    clint_timer_if.slave bus,
    output logic         mtip,
    output logic         msip
);

    state_t      state;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip_q;
    logic [63:0] rdata_q;
    logic        err_q;
    logic        tick;
    logic        accept;
    logic        wr;
    logic [15:0] word_addr;
    logic        hit_msip;
    logic        hit_cmp;
    logic        hit_mtime;
    logic        hit;
    logic [7:0]  wmask;
    logic        mtime_wr;
    logic [63:0] rd_data;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        accept    = state == IDLE && bus.req_valid;
        wr        = accept && bus.req_wen;
        word_addr = bus.req_addr & 16'hFFF8;
        hit_msip  = word_addr == CLINT_MSIP;
        hit_cmp   = word_addr == CLINT_MTIMECMP;
        hit_mtime = word_addr == CLINT_MTIME;
        hit       = hit_msip || hit_cmp || hit_mtime;
`ifdef CLINT_WMASK_EN
        wmask     = bus.req_wmask;
`else
        // every byte lane is written regardless of the mask
        wmask     = bus.req_wmask | 8'hFF;
`endif
        // an all-zero mask is a no-op write, so the tick is not suppressed
        mtime_wr  = wr && hit_mtime && |wmask;
        rd_data   = hit_msip  ? {63'd0, msip_q} :
                    hit_cmp   ? mtimecmp :
                    hit_mtime ? mtime : 64'd0;
    end

    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign mtip           = mtime >= mtimecmp;
    assign msip           = msip_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mtime    <= MTIME_RST;
            mtimecmp <= '1;
            msip_q   <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // a write beats the tick; the prescaler itself keeps counting
            mtime <= mtime_wr ? merge_bytes(mtime, bus.req_wdata, wmask) :
                     tick     ? mtime + 64'd1 : mtime;
            if (wr && hit_cmp)
                mtimecmp <= merge_bytes(mtimecmp, bus.req_wdata, wmask);
            if (wr && hit_msip && wmask[0])
                msip_q <= bus.req_wdata[0];
            if (accept) begin
                state   <= RESP;
                rdata_q <= bus.req_wen ? 64'd0 : rd_data;
                err_q   <= !hit;
            end else if (state == RESP && bus.resp_ready) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: self-checking bench for clint_timer (TICK_DIV=1 and TICK_DIV=4 side by side)
module tb_clint_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_wen = 1'b0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_ready = 1'b0;
    logic        mtip1, msip1, mtip4, msip4;
    longint      cyc;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    clint_timer_if b1();
    clint_timer_if b4();

    assign b1.req_valid  = req_valid;
    assign b1.req_wen    = req_wen;
    assign b1.req_addr   = req_addr;
    assign b1.req_wdata  = req_wdata;
    assign b1.req_wmask  = req_wmask;
    assign b1.resp_ready = resp_ready;
    assign b4.req_valid  = req_valid;
    assign b4.req_wen    = req_wen;
    assign b4.req_addr   = req_addr;
    assign b4.req_wdata  = req_wdata;
    assign b4.req_wmask  = req_wmask;
    assign b4.resp_ready = resp_ready;

    clint_timer #(.TICK_DIV(1), .MTIME_RST(64'd0)) dut1 (
        .clk(clk), .rst(rst), .bus(b1.slave), .mtip(mtip1), .msip(msip1)
    );

    clint_timer #(.TICK_DIV(4), .MTIME_RST(64'd0)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave), .mtip(mtip4), .msip(msip4)
    );

    // cycle index since reset release; cycle k ticks when k % div == div-1
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    // reference model: mtime = value last written + ticks elapsed since the cycle after the write
    longint      ms_start[2];
    logic [63:0] ms_val[2];
    logic [63:0] m_cmp;
    logic        m_msip;

    function automatic logic [63:0] mt(input int i, input longint n);
        longint d;
        d = (i == 1) ? 4 : 1;
        return ms_val[i] + 64'(n / d - ms_start[i] / d);
    endfunction

    function automatic logic [63:0] mrg(input logic [63:0] o, input logic [63:0] nw, input logic [7:0] m);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = m[k] ? nw[k*8 +: 8] : o[k*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms_start[i] = 0;
            ms_val[i]   = 64'd0;
        end
        m_cmp  = '1;
        m_msip = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_irq();
        chk("mtip1", 64'(mtip1), 64'(mt(0, cyc) >= m_cmp));
        chk("mtip4", 64'(mtip4), 64'(mt(1, cyc) >= m_cmp));
        chk("msip1", 64'(msip1), 64'(m_msip));
        chk("msip4", 64'(msip4), 64'(m_msip));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            chk_irq();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one full transaction; entered and left just after a falling edge
    task automatic xact(input logic wen, input logic [15:0] addr, input logic [63:0] wd,
                        input logic [7:0] wm, output logic [63:0] rd1, output logic [63:0] rd4,
                        output logic er1);
        longint      acc;
        logic [63:0] e[2];
        logic [63:0] tmp;
        logic        ee, s_ms, s_cmp, s_mt;
        logic [7:0]  eff;
        chk_irq();
        acc   = cyc;
        s_ms  = addr[15:3] == 13'h0000;
        s_cmp = addr[15:3] == 13'h0800;
        s_mt  = addr[15:3] == 13'h17FF;
        ee    = !(s_ms || s_cmp || s_mt);
        for (int i = 0; i < 2; i++)
            e[i] = wen ? 64'd0 : s_ms ? {63'd0, m_msip} : s_cmp ? m_cmp : s_mt ? mt(i, acc) : 64'd0;
        if (wen) begin
`ifdef CLINT_WMASK_EN
            eff = wm;
`else
            eff = 8'hFF;
`endif
            if (s_ms && eff[0]) m_msip = wd[0];
            if (s_cmp) m_cmp = mrg(m_cmp, wd, eff);
            if (s_mt && |eff)
                for (int i = 0; i < 2; i++) begin
                    tmp = mrg(mt(i, acc), wd, eff);
                    ms_val[i]   = tmp;
                    ms_start[i] = acc + 1;
                end
        end
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = wm;
        @(posedge clk);
        @(negedge clk);
        chk("resp_valid1", 64'(b1.resp_valid), 64'd1);
        chk("req_ready1_busy", 64'(b1.req_ready), 64'd0);
        chk("rdata1", b1.resp_rdata, e[0]);
        chk("err1", 64'(b1.resp_err), 64'(ee));
        chk("resp_valid4", 64'(b4.resp_valid), 64'd1);
        chk("rdata4", b4.resp_rdata, e[1]);
        chk("err4", 64'(b4.resp_err), 64'(ee));
        chk_irq();
        rd1 = b1.resp_rdata;
        rd4 = b4.resp_rdata;
        er1 = b1.resp_err;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("req_ready1_back", 64'(b1.req_ready), 64'd1);
        chk("resp_valid1_done", 64'(b1.resp_valid), 64'd0);
    endtask

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [63:0] r1, r4, hold1, hold4, wd;
        logic        e1;
        logic [15:0] ad;
        logic [7:0]  wm;
        longint      acc;

        tbl[0]  = '{1'b1, 16'h0000, 64'hFFFF,                 64'd0,                    1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 64'd0,                    64'd1,                    1'b0};
        tbl[2]  = '{1'b0, 16'h0006, 64'd0,                    64'd1,                    1'b0};
        tbl[3]  = '{1'b1, 16'h4000, 64'h1234_5678_9ABC_DEF0,  64'd0,                    1'b0};
        tbl[4]  = '{1'b0, 16'h4007, 64'd0,                    64'h1234_5678_9ABC_DEF0,  1'b0};
        tbl[5]  = '{1'b0, 16'h1234, 64'd0,                    64'd0,                    1'b1};
        tbl[6]  = '{1'b1, 16'h1234, 64'hDEAD,                 64'd0,                    1'b1};
        tbl[7]  = '{1'b1, 16'h0000, 64'd0,                    64'd0,                    1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 64'd0,                    64'd0,                    1'b0};
        tbl[9]  = '{1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF,  64'd0,                    1'b0};
        tbl[10] = '{1'b0, 16'hBFF0, 64'd0,                    64'd0,                    1'b1};
        tbl[11] = '{1'b0, 16'h4008, 64'd0,                    64'd0,                    1'b1};
        tbl[12] = '{1'b1, 16'h0003, 64'h3,                    64'd0,                    1'b0};
        tbl[13] = '{1'b0, 16'h0000, 64'd0,                    64'd1,                    1'b0};
        tbl[14] = '{1'b1, 16'h0000, 64'd0,                    64'd0,                    1'b0};

        model_reset();
        @(negedge clk);
        chk("rst_resp_valid1", 64'(b1.resp_valid), 64'd0);
        chk("rst_req_ready1", 64'(b1.req_ready), 64'd1);
        chk("rst_rdata1", b1.resp_rdata, 64'd0);
        chk("rst_err1", 64'(b1.resp_err), 64'd0);
        chk("rst_mtip1", 64'(mtip1), 64'd0);
        chk("rst_msip4", 64'(msip4), 64'd0);
        do_reset();

        // mtime after 10 idle cycles
        idle(10);
        xact(1'b0, 16'hBFF8, 64'd0, 8'hFF, r1, r4, e1);
        chk("mtime10_div1", r1, 64'd10);
        chk("mtime10_div4", r4, 64'd2);
        chk("mtime10_err", 64'(e1), 64'd0);

        // mtimecmp crossing
        xact(1'b1, 16'hBFF8, 64'd5, 8'hFF, r1, r4, e1);
        xact(1'b1, 16'h4000, 64'd20, 8'hFF, r1, r4, e1);
        idle(40);
        chk("mtip1_high", 64'(mtip1), 64'd1);
        xact(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r1, r4, e1);
        chk("mtip1_cleared", 64'(mtip1), 64'd0);

        for (int i = 0; i < 15; i++) begin
            xact(tbl[i].wen, tbl[i].addr, tbl[i].wdata, 8'hFF, r1, r4, e1);
            chk($sformatf("tbl%0d_rdata", i), r1, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 64'(e1), 64'(tbl[i].exp_err));
        end

        // partial byte write to mtimecmp
        xact(1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hFF, r1, r4, e1);
        xact(1'b1, 16'h4000, 64'hAA, 8'h01, r1, r4, e1);
        xact(1'b0, 16'h4000, 64'd0, 8'hFF, r1, r4, e1);
`ifdef CLINT_WMASK_EN
        chk("wmask_cmp", r1, 64'h1122_3344_5566_77AA);
`else
        chk("wmask_cmp", r1, 64'hAA);
`endif
        xact(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r1, r4, e1);

        // mtime wrap: 8 cycles hold exactly two ticks at TICK_DIV=4
        xact(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, r1, r4, e1);
        idle(7);
        xact(1'b0, 16'hBFF8, 64'd0, 8'hFF, r1, r4, e1);
        chk("wrap_div4", r4, 64'd0);
        chk("wrap_div1", r1, 64'd6);

        // response held while resp_ready is low; a request during RESP is ignored
        chk_irq();
        acc = cyc;
        hold1 = mt(0, acc);
        hold4 = mt(1, acc);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 16'hBFF8;
        req_wmask = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req_wen   = 1'b1;
        req_addr  = 16'h0000;
        req_wdata = 64'd1;
        repeat (5) begin
            chk("hold_valid1", 64'(b1.resp_valid), 64'd1);
            chk("hold_ready1", 64'(b1.req_ready), 64'd0);
            chk("hold_rdata1", b1.resp_rdata, hold1);
            chk("hold_rdata4", b4.resp_rdata, hold4);
            chk_irq();
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("hold_released", 64'(b1.resp_valid), 64'd0);
        xact(1'b0, 16'h0000, 64'd0, 8'hFF, r1, r4, e1);
        chk("hold_ignored_write", r1, 64'd0);

        // reset while a response is pending
        xact(1'b1, 16'h4000, 64'h100, 8'hFF, r1, r4, e1);
        xact(1'b1, 16'hBFF8, 64'h50, 8'hFF, r1, r4, e1);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid1", 64'(b1.resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_drop_valid1", 64'(b1.resp_valid), 64'd0);
        chk("rst_drop_valid4", 64'(b4.resp_valid), 64'd0);
        chk("rst_drop_rdata1", b1.resp_rdata, 64'd0);
        do_reset();
        xact(1'b0, 16'h4000, 64'd0, 8'hFF, r1, r4, e1);
        chk("rst_mtimecmp", r1, 64'hFFFF_FFFF_FFFF_FFFF);
        xact(1'b0, 16'hBFF8, 64'd0, 8'hFF, r1, r4, e1);
        chk("rst_mtime_div1", r1, 64'd2);
        chk("rst_mtime_div4", r4, 64'd0);

        // randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            idle($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       ad = 16'h0000;
                1:       ad = 16'h4000;
                2:       ad = 16'hBFF8;
                default: ad = 16'($urandom);
            endcase
            if (ad[15:3] != 13'h17FF || $urandom_range(0, 1) == 1)
                ad[2:0] = 3'($urandom_range(0, 7));
            wd = $urandom_range(0, 1) ? {32'($urandom), 32'($urandom)} : mt(0, cyc) + 64'($urandom_range(0, 40));
            wm = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
            xact(1'($urandom_range(0, 1)), ad, wd, wm, r1, r4, e1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
